// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: parameter defaults, timer width
// and the arbiter FSM state encoding.
package sram_arbiter_pkg;

    localparam int DEF_ADDR_W        = 19;
    localparam int DEF_DATA_W        = 8;
    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_CPU_MAX_WAIT  = 4;

    // Wide enough for ACCESS_CYCLES and CPU_MAX_WAIT (both at most 15)
    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/sram_access_timer.sv
// Down-counter that times the strobe phase of one SRAM access.
module sram_access_timer import sram_arbiter_pkg::*; #(
    parameter int WIDTH = TIMER_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;

    // zero flags the final strobe cycle: the count runs out at the coming edge
    assign zero = (count_r <= ONE);

    // Count register: load on grant, decrement while the access is running
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: VGA reads have priority, CPU reads/writes are
// guaranteed service after CPU_MAX_WAIT consecutive VGA grants.
module sram_arbiter import sram_arbiter_pkg::*; #(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int CPU_MAX_WAIT  = DEF_CPU_MAX_WAIT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iVgaReq,
    input  logic [ADDR_W-1:0] iVgaAddr,
    output logic              oVgaAck,
    output logic [DATA_W-1:0] oVgaData,
    input  logic              iCpuReq,
    input  logic              iCpuWe,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuData,
    output logic              oCpuAck,
    output logic [DATA_W-1:0] oCpuData,
    output logic [ADDR_W-1:0] oSramAddr,
    output logic [DATA_W-1:0] oSramDataOut,
    output logic              oSramDataOe,
    input  logic [DATA_W-1:0] iSramDataIn,
    output logic              oSramCe,
    output logic              oSramWe,
    output logic              oSramOe
);

    localparam logic [TIMER_W-1:0] ACCESS_LOAD = TIMER_W'(ACCESS_CYCLES);
    localparam logic [TIMER_W-1:0] MAX_WAIT    = TIMER_W'(CPU_MAX_WAIT);
    localparam logic [TIMER_W-1:0] WAIT_ONE    = TIMER_W'(1);

    state_e              state_r, state_s;
    logic [TIMER_W-1:0]  wait_r, wait_s;
    logic                is_cpu_r, is_cpu_s;
    logic                is_write_r, is_write_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   dout_r, dout_s;
    logic                doe_r, doe_s;
    logic                ce_r, ce_s;
    logic                we_r, we_s;
    logic                oe_r, oe_s;
    logic                vga_ack_r, vga_ack_s;
    logic                cpu_ack_r, cpu_ack_s;
    logic [DATA_W-1:0]   vga_data_r, vga_data_s;
    logic [DATA_W-1:0]   cpu_data_r, cpu_data_s;
    logic                timer_load_s, timer_en_s, timer_zero_s;
    logic                grant_cpu_s;

    sram_access_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (timer_load_s),
        .load_value (ACCESS_LOAD),
        .en         (timer_en_s),
        .zero       (timer_zero_s)
    );

    // The CPU only overrides a concurrent VGA request once it has waited its quota
    assign grant_cpu_s = iCpuReq && (!iVgaReq || (wait_r == MAX_WAIT));

    // Next-state and next-output logic; every bus output is registered below
    always_comb begin
        state_s      = state_r;
        wait_s       = wait_r;
        is_cpu_s     = is_cpu_r;
        is_write_s   = is_write_r;
        addr_s       = addr_r;
        dout_s       = dout_r;
        doe_s        = doe_r;
        ce_s         = ce_r;
        we_s         = we_r;
        oe_s         = oe_r;
        vga_ack_s    = 1'b0;
        cpu_ack_s    = 1'b0;
        vga_data_s   = vga_data_r;
        cpu_data_s   = cpu_data_r;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (iCpuReq || iVgaReq) begin
                    state_s      = ST_ACCESS;
                    timer_load_s = 1'b1;
                    ce_s         = 1'b0;
                    if (grant_cpu_s) begin
                        is_cpu_s   = 1'b1;
                        is_write_s = iCpuWe;
                        addr_s     = iCpuAddr;
                        wait_s     = {TIMER_W{1'b0}};
                        we_s       = ~iCpuWe;
                        oe_s       = iCpuWe;
                        doe_s      = iCpuWe;
                        if (iCpuWe) begin
                            dout_s = iCpuData;
                        end else begin
                            dout_s = dout_r;
                        end
                    end else begin
                        is_cpu_s   = 1'b0;
                        is_write_s = 1'b0;
                        addr_s     = iVgaAddr;
                        we_s       = 1'b1;
                        oe_s       = 1'b0;
                        doe_s      = 1'b0;
                        if (iCpuReq && (wait_r != MAX_WAIT)) begin
                            wait_s = wait_r + WAIT_ONE;
                        end else begin
                            wait_s = wait_r;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                timer_en_s = 1'b1;
                if (timer_zero_s) begin
                    state_s = ST_DONE;
                    ce_s    = 1'b1;
                    we_s    = 1'b1;
                    oe_s    = 1'b1;
                    if (is_cpu_r) begin
                        cpu_ack_s = 1'b1;
                    end else begin
                        vga_ack_s = 1'b1;
                    end
                    if (!is_write_r && is_cpu_r) begin
                        cpu_data_s = iSramDataIn;
                    end else if (!is_write_r) begin
                        vga_data_s = iSramDataIn;
                    end else begin
                        cpu_data_s = cpu_data_r;
                    end
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                // Address and write data stay on the bus through DONE for hold time
                state_s = ST_IDLE;
                doe_s   = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                ce_s    = 1'b1;
                we_s    = 1'b1;
                oe_s    = 1'b1;
                doe_s   = 1'b0;
            end
        endcase
    end

    // State, grant bookkeeping and registered SRAM/requester outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            wait_r     <= {TIMER_W{1'b0}};
            is_cpu_r   <= 1'b0;
            is_write_r <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            dout_r     <= {DATA_W{1'b0}};
            doe_r      <= 1'b0;
            ce_r       <= 1'b1;
            we_r       <= 1'b1;
            oe_r       <= 1'b1;
            vga_ack_r  <= 1'b0;
            cpu_ack_r  <= 1'b0;
            vga_data_r <= {DATA_W{1'b0}};
            cpu_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            wait_r     <= wait_s;
            is_cpu_r   <= is_cpu_s;
            is_write_r <= is_write_s;
            addr_r     <= addr_s;
            dout_r     <= dout_s;
            doe_r      <= doe_s;
            ce_r       <= ce_s;
            we_r       <= we_s;
            oe_r       <= oe_s;
            vga_ack_r  <= vga_ack_s;
            cpu_ack_r  <= cpu_ack_s;
            vga_data_r <= vga_data_s;
            cpu_data_r <= cpu_data_s;
        end
    end

    assign oSramAddr    = addr_r;
    assign oSramDataOut = dout_r;
    assign oSramDataOe  = doe_r;
    assign oSramCe      = ce_r;
    assign oSramWe      = we_r;
    assign oSramOe      = oe_r;
    assign oVgaAck      = vga_ack_r;
    assign oCpuAck      = cpu_ack_r;
    assign oVgaData     = vga_data_r;
    assign oCpuData     = cpu_data_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized
// run against a transaction-level scheduling model and a simple SRAM model.
module tb_sram_arbiter;

    localparam int AW   = 19;
    localparam int DW   = 8;
    localparam int AC   = 2;
    localparam int MAXW = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iVgaReq;
    logic [AW-1:0] iVgaAddr;
    logic          oVgaAck;
    logic [DW-1:0] oVgaData;
    logic          iCpuReq;
    logic          iCpuWe;
    logic [AW-1:0] iCpuAddr;
    logic [DW-1:0] iCpuData;
    logic          oCpuAck;
    logic [DW-1:0] oCpuData;
    logic [AW-1:0] oSramAddr;
    logic [DW-1:0] oSramDataOut;
    logic          oSramDataOe;
    logic [DW-1:0] sram_rdata;
    logic          oSramCe, oSramWe, oSramOe;

    int checks = 0;
    int passes = 0;

    logic       mem_init;
    logic [7:0] sram_mem [0:255];
    logic [7:0] ref_mem  [0:255];

    always #5 Clock = ~Clock;

    sram_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .ACCESS_CYCLES (AC),
        .CPU_MAX_WAIT  (MAXW)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iVgaReq      (iVgaReq),
        .iVgaAddr     (iVgaAddr),
        .oVgaAck      (oVgaAck),
        .oVgaData     (oVgaData),
        .iCpuReq      (iCpuReq),
        .iCpuWe       (iCpuWe),
        .iCpuAddr     (iCpuAddr),
        .iCpuData     (iCpuData),
        .oCpuAck      (oCpuAck),
        .oCpuData     (oCpuData),
        .oSramAddr    (oSramAddr),
        .oSramDataOut (oSramDataOut),
        .oSramDataOe  (oSramDataOe),
        .iSramDataIn  (sram_rdata),
        .oSramCe      (oSramCe),
        .oSramWe      (oSramWe),
        .oSramOe      (oSramOe)
    );

    function automatic logic [7:0] init_val(int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Asynchronous-read SRAM; writes need chip enable, write strobe and driver enable
    assign sram_rdata = (!oSramCe && !oSramOe) ? sram_mem[oSramAddr[7:0]] : 8'hEE;

    always @(posedge Clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
        end else if (!oSramCe && !oSramWe && oSramDataOe) begin
            sram_mem[oSramAddr[7:0]] <= oSramDataOut;
        end
    end

    task automatic test_reset();
        Reset = 1'b1; mem_init = 1'b1;
        iVgaReq = 1'b0; iVgaAddr = '0; iCpuReq = 1'b0; iCpuWe = 1'b0; iCpuAddr = '0; iCpuData = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++; if (oSramCe !== 1'b1) $display("FAIL reset_ce: got %b expected 1", oSramCe); else passes++;
        checks++; if (oSramWe !== 1'b1) $display("FAIL reset_we: got %b expected 1", oSramWe); else passes++;
        checks++; if (oSramOe !== 1'b1) $display("FAIL reset_oe: got %b expected 1", oSramOe); else passes++;
        checks++; if (oSramDataOe !== 1'b0) $display("FAIL reset_doe: got %b expected 0", oSramDataOe); else passes++;
        checks++; if (oVgaAck !== 1'b0) $display("FAIL reset_vga_ack: got %b expected 0", oVgaAck); else passes++;
        checks++; if (oCpuAck !== 1'b0) $display("FAIL reset_cpu_ack: got %b expected 0", oCpuAck); else passes++;
        checks++; if (oSramAddr !== 19'h0) $display("FAIL reset_addr: got %0h expected 0", oSramAddr); else passes++;
        checks++; if (oSramDataOut !== 8'h00) $display("FAIL reset_dout: got %0h expected 0", oSramDataOut); else passes++;
        checks++; if (oVgaData !== 8'h00) $display("FAIL reset_vga_data: got %0h expected 0", oVgaData); else passes++;
        checks++; if (oCpuData !== 8'h00) $display("FAIL reset_cpu_data: got %0h expected 0", oCpuData); else passes++;
        mem_init = 1'b0; Reset = 1'b0;
    endtask

    task automatic test_cpu_write();
        int we_low, ack_at, acks;
        bit dout_ok;
        we_low = 0; ack_at = -1; acks = 0; dout_ok = 1'b1;
        iCpuReq = 1'b1; iCpuWe = 1'b1; iCpuAddr = 19'h00010; iCpuData = 8'hA5;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            if (!oSramWe) we_low++;
            if (k <= 3 && oSramDataOut !== 8'hA5) dout_ok = 1'b0;
            if (oCpuAck) begin acks++; ack_at = k; end
            if (oVgaAck) acks++;
            if (k == 3) begin
                checks++; if (oSramDataOe !== 1'b1) $display("FAIL wr_doe_hold: got %b expected 1", oSramDataOe); else passes++;
                checks++; if (oSramAddr !== 19'h00010) $display("FAIL wr_addr_hold: got %0h expected 10", oSramAddr); else passes++;
                iCpuReq = 1'b0;
            end
        end
        checks++; if (we_low != 2) $display("FAIL wr_we_cycles: got %0d expected 2", we_low); else passes++;
        checks++; if (ack_at != 3) $display("FAIL wr_ack_cycle: got %0d expected 3", ack_at); else passes++;
        checks++; if (acks != 1) $display("FAIL wr_ack_count: got %0d expected 1", acks); else passes++;
        checks++; if (!dout_ok) $display("FAIL wr_dout: got unstable expected a5 for 3 cycles"); else passes++;
        checks++; if (sram_mem[16] !== 8'hA5) $display("FAIL wr_mem: got %0h expected a5", sram_mem[16]); else passes++;
    endtask

    task automatic test_cpu_read();
        int oe_low, ack_at;
        oe_low = 0; ack_at = -1;
        iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 19'h00010; iCpuData = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            if (!oSramOe) oe_low++;
            if (oCpuAck) begin
                ack_at = k;
                checks++; if (oCpuData !== 8'hA5) $display("FAIL rd_data: got %0h expected a5", oCpuData); else passes++;
                iCpuReq = 1'b0;
            end
            if (k == 4) begin
                checks++; if (oCpuData !== 8'hA5) $display("FAIL rd_data_hold: got %0h expected a5", oCpuData); else passes++;
            end
        end
        checks++; if (oe_low != 2) $display("FAIL rd_oe_cycles: got %0d expected 2", oe_low); else passes++;
        checks++; if (ack_at != 3) $display("FAIL rd_ack_cycle: got %0d expected 3", ack_at); else passes++;
    endtask

    task automatic test_vga_stream();
        int n;
        n = 0;
        iVgaReq = 1'b1; iVgaAddr = 19'h00000;
        for (int k = 1; k <= 17; k++) begin
            @(negedge Clock);
            checks++; if (oCpuAck !== 1'b0) $display("FAIL vga_stray_cpu_ack: got %b expected 0", oCpuAck); else passes++;
            if (oVgaAck) begin
                checks++; if (k != 4 * n + 3) $display("FAIL vga_ack_cycle: got %0d expected %0d", k, 4 * n + 3); else passes++;
                checks++; if (oVgaData !== init_val(n)) $display("FAIL vga_data: got %0h expected %0h", oVgaData, init_val(n)); else passes++;
                n++;
                if (n == 4) iVgaReq = 1'b0; else iVgaAddr = 19'(n);
            end
        end
        checks++; if (n != 4) $display("FAIL vga_ack_total: got %0d expected 4", n); else passes++;
    endtask

    task automatic test_fairness();
        int w, acks, last_ack;
        logic exp_cpu;
        w = 0; acks = 0; last_ack = -1;
        iVgaReq = 1'b1; iVgaAddr = 19'h00002;
        iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 19'h00010;
        for (int k = 1; k <= 60 && acks < 10; k++) begin
            @(negedge Clock);
            checks++; if (oVgaAck && oCpuAck) $display("FAIL fair_dual_ack: got 11 expected one ack"); else passes++;
            if (oVgaAck || oCpuAck) begin
                exp_cpu = (w == MAXW);
                w = exp_cpu ? 0 : ((w < MAXW) ? w + 1 : w);
                checks++; if (oCpuAck !== exp_cpu) $display("FAIL fair_grant%0d: got cpu=%b expected cpu=%b", acks, oCpuAck, exp_cpu); else passes++;
                if (last_ack >= 0) begin
                    checks++; if (k - last_ack != AC + 2) $display("FAIL fair_spacing: got %0d expected %0d", k - last_ack, AC + 2); else passes++;
                end
                last_ack = k; acks++;
                if (acks == 10) begin iVgaReq = 1'b0; iCpuReq = 1'b0; end
            end
        end
        checks++; if (acks != 10) $display("FAIL fair_ack_total: got %0d expected 10", acks); else passes++;
    endtask

    task automatic test_simultaneous();
        int vga_at, cpu_at;
        vga_at = -1; cpu_at = -1;
        @(negedge Clock);
        iVgaReq = 1'b1; iVgaAddr = 19'h00001;
        iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 19'h00010;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            if (oVgaAck && vga_at < 0) begin
                vga_at = k; iVgaReq = 1'b0;
                checks++; if (oVgaData !== init_val(1)) $display("FAIL sim_vga_data: got %0h expected %0h", oVgaData, init_val(1)); else passes++;
            end
            if (oCpuAck && cpu_at < 0) begin
                cpu_at = k; iCpuReq = 1'b0;
                checks++; if (oCpuData !== 8'hA5) $display("FAIL sim_cpu_data: got %0h expected a5", oCpuData); else passes++;
            end
        end
        checks++; if (vga_at != 3) $display("FAIL sim_vga_ack: got %0d expected 3", vga_at); else passes++;
        checks++; if (cpu_at != 7) $display("FAIL sim_cpu_ack: got %0d expected 7", cpu_at); else passes++;
    endtask

    task automatic test_reset_mid_access();
        int ack_at;
        ack_at = -1;
        iCpuReq = 1'b1; iCpuWe = 1'b1; iCpuAddr = 19'h00020; iCpuData = 8'h3C;
        @(negedge Clock);
        checks++; if (oSramWe !== 1'b0) $display("FAIL rst_pre_we: got %b expected 0", oSramWe); else passes++;
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if ({oSramCe, oSramWe, oSramOe} !== 3'b111) $display("FAIL rst_strobes: got %b expected 111", {oSramCe, oSramWe, oSramOe}); else passes++;
        checks++; if (oSramDataOe !== 1'b0) $display("FAIL rst_doe: got %b expected 0", oSramDataOe); else passes++;
        checks++; if (oCpuAck !== 1'b0) $display("FAIL rst_no_ack: got %b expected 0", oCpuAck); else passes++;
        Reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            if (oCpuAck) begin ack_at = k; iCpuReq = 1'b0; end
        end
        checks++; if (ack_at != 3) $display("FAIL rst_restart_ack: got %0d expected 3", ack_at); else passes++;
        checks++; if (sram_mem[32] !== 8'h3C) $display("FAIL rst_restart_mem: got %0h expected 3c", sram_mem[32]); else passes++;
    endtask

    task automatic test_random();
        int free_at, exp_at, w, bad_mem;
        logic exp_cpu, exp_read;
        logic [7:0] exp_data, last_cpu, last_vga;
        Reset = 1'b1; iVgaReq = 1'b0; iCpuReq = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = sram_mem[i];
        free_at = 0; exp_at = -1; w = 0; exp_cpu = 1'b0; exp_read = 1'b0; exp_data = 8'h00;
        last_cpu = 8'h00; last_vga = 8'h00;
        for (int c = 0; c < 400; c++) begin
            @(posedge Clock);
            // One transaction at a time: decide the grant whenever the arbiter is free
            if (c >= free_at && (iCpuReq || iVgaReq)) begin
                exp_cpu = iCpuReq && (!iVgaReq || w == MAXW);
                if (exp_cpu) w = 0;
                else if (iCpuReq && w < MAXW) w = w + 1;
                if (exp_cpu && iCpuWe) begin
                    ref_mem[iCpuAddr[7:0]] = iCpuData; exp_read = 1'b0;
                end else begin
                    exp_read = 1'b1;
                    exp_data = exp_cpu ? ref_mem[iCpuAddr[7:0]] : ref_mem[iVgaAddr[7:0]];
                end
                exp_at = c + AC; free_at = c + AC + 2;
            end
            @(negedge Clock);
            if (c == exp_at) begin
                if (exp_read && exp_cpu) last_cpu = exp_data;
                if (exp_read && !exp_cpu) last_vga = exp_data;
                checks++; if ({oCpuAck, oVgaAck} !== {exp_cpu, !exp_cpu}) $display("FAIL rnd_ack c=%0d: got %b expected %b", c, {oCpuAck, oVgaAck}, {exp_cpu, !exp_cpu}); else passes++;
                if (exp_cpu && $urandom_range(1, 0) == 1) begin
                    iCpuWe = 1'($urandom_range(1, 0)); iCpuAddr = 19'($urandom_range(15, 0)); iCpuData = 8'($urandom);
                end else if (exp_cpu) begin
                    iCpuReq = 1'b0;
                end else if ($urandom_range(1, 0) == 1) begin
                    iVgaAddr = 19'($urandom_range(15, 0));
                end else begin
                    iVgaReq = 1'b0;
                end
            end else begin
                checks++; if ({oCpuAck, oVgaAck} !== 2'b00) $display("FAIL rnd_idle_ack c=%0d: got %b expected 00", c, {oCpuAck, oVgaAck}); else passes++;
            end
            checks++; if (oCpuData !== last_cpu) $display("FAIL rnd_cpu_data c=%0d: got %0h expected %0h", c, oCpuData, last_cpu); else passes++;
            checks++; if (oVgaData !== last_vga) $display("FAIL rnd_vga_data c=%0d: got %0h expected %0h", c, oVgaData, last_vga); else passes++;
            if (!iCpuReq && $urandom_range(2, 0) == 0) begin
                iCpuReq = 1'b1; iCpuWe = 1'($urandom_range(1, 0));
                iCpuAddr = 19'($urandom_range(15, 0)); iCpuData = 8'($urandom);
            end
            if (!iVgaReq && $urandom_range(2, 0) == 0) begin
                iVgaReq = 1'b1; iVgaAddr = 19'($urandom_range(15, 0));
            end
        end
        iCpuReq = 1'b0; iVgaReq = 1'b0;
        repeat (AC + 3) @(negedge Clock);
        bad_mem = 0;
        for (int i = 0; i < 16; i++) if (sram_mem[i] !== ref_mem[i]) bad_mem++;
        checks++; if (bad_mem != 0) $display("FAIL rnd_mem: got %0d differing words expected 0", bad_mem); else passes++;
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_vga_stream();
        test_fairness();
        test_simultaneous();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
